// File: rtl/mem_sequencer.sv
// mem_sequencer: serialises the core's fetch/load/store ports onto one
// single-port, variable-latency RAM and emits the core's one-cycle commit
// pulse (o_core_clk_en) once every access of the current instruction is done.
// Optional build macro MEM_SEQ_STATS_EN adds o_instr_count and o_wait_cycles.
module mem_sequencer #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   i_fetch_addr,
  output logic [DATA_WIDTH:0]   o_fetch_data,
  input  logic                  i_read_req,
  input  logic [ADDR_WIDTH:0]   i_read_addr,
  output logic [DATA_WIDTH:0]   o_read_data,
  input  logic                  i_write_enable,
  input  logic [3:0]            i_byte_enable,
  input  logic [ADDR_WIDTH:0]   i_write_addr,
  input  logic [DATA_WIDTH:0]   i_write_data,
  input  logic                  i_halt,
  output logic                  o_core_clk_en,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [3:0]            o_mem_be,
  output logic [ADDR_WIDTH:0]   o_mem_addr,
  output logic [DATA_WIDTH:0]   o_mem_wdata,
  input  logic [DATA_WIDTH:0]   i_mem_rdata,
  input  logic                  i_mem_ready
`ifdef MEM_SEQ_STATS_EN
  ,
  output logic [31:0]           o_instr_count,
  output logic [31:0]           o_wait_cycles
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_READ,
    S_WRITE,
    S_COMMIT,
    S_HALT
  } state_t;

  state_t state;
  logic   req_q;    // a RAM request is outstanding in the current state
  logic   wr_pend;  // store sampled in decode, issued after any load

  // Sequencer: one access per state, request flag cleared on completion.
  // After reset, and between a load and a following store, req_q is low for
  // one cycle so the RAM always sees req drop after a completed transfer.
  // The core is frozen while clk_en=0, so its address/data inputs are stable
  // and can be steered straight onto the RAM port while req_q is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FETCH;
      req_q         <= 1'b0;
      wr_pend       <= 1'b0;
      o_core_clk_en <= 1'b0;
      o_fetch_data  <= '0;
      o_read_data   <= '0;
    end else begin
      o_core_clk_en <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (i_mem_ready) begin
            o_fetch_data <= i_mem_rdata;
            req_q        <= 1'b0;
            state        <= S_DECODE;
          end
        end
        S_DECODE: begin
          wr_pend <= i_write_enable;
          if (i_read_req) begin
            state <= S_READ;
            req_q <= 1'b1;
          end else if (i_write_enable) begin
            state <= S_WRITE;
            req_q <= 1'b1;
          end else begin
            state         <= S_COMMIT;
            o_core_clk_en <= 1'b1;
          end
        end
        S_READ: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (i_mem_ready) begin
            o_read_data <= i_mem_rdata;
            req_q       <= 1'b0;
            if (wr_pend) begin
              state <= S_WRITE;
            end else begin
              state         <= S_COMMIT;
              o_core_clk_en <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (i_mem_ready) begin
            req_q         <= 1'b0;
            state         <= S_COMMIT;
            o_core_clk_en <= 1'b1;
          end
        end
        S_COMMIT: begin
          if (i_halt) begin
            state <= S_HALT;
          end else begin
            state <= S_FETCH;
            req_q <= 1'b1;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req = req_q;

  // RAM command fields: driven only while a request is outstanding, zero otherwise.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (req_q) begin
      case (state)
        S_FETCH: o_mem_addr = i_fetch_addr;
        S_READ:  o_mem_addr = i_read_addr;
        S_WRITE: begin
          o_mem_we    = 1'b1;
          o_mem_be    = i_byte_enable;
          o_mem_addr  = i_write_addr;
          o_mem_wdata = i_write_data;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_SEQ_STATS_EN
  // Statistics: committed instructions and RAM wait-state cycles, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_instr_count <= '0;
      o_wait_cycles <= '0;
    end else begin
      if (state == S_COMMIT)
        o_instr_count <= o_instr_count + 32'd1;
      if (req_q && !i_mem_ready)
        o_wait_cycles <= o_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed self-checking bench for mem_sequencer: a small RAM model with
// per-address wait states, a handshake/commit log, hand-computed expectations.
module tb_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_fetch_addr;
  logic [31:0] o_fetch_data;
  logic        i_read_req;
  logic [31:0] i_read_addr;
  logic [31:0] o_read_data;
  logic        i_write_enable;
  logic [3:0]  i_byte_enable;
  logic [31:0] i_write_addr;
  logic [31:0] i_write_data;
  logic        i_halt;
  logic        o_core_clk_en;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ready;
`ifdef MEM_SEQ_STATS_EN
  logic [31:0] o_instr_count;
  logic [31:0] o_wait_cycles;
`endif

  mem_sequencer #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_fetch_addr   (i_fetch_addr),
    .o_fetch_data   (o_fetch_data),
    .i_read_req     (i_read_req),
    .i_read_addr    (i_read_addr),
    .o_read_data    (o_read_data),
    .i_write_enable (i_write_enable),
    .i_byte_enable  (i_byte_enable),
    .i_write_addr   (i_write_addr),
    .i_write_data   (i_write_data),
    .i_halt         (i_halt),
    .o_core_clk_en  (o_core_clk_en),
    .o_mem_req      (o_mem_req),
    .o_mem_we       (o_mem_we),
    .o_mem_be       (o_mem_be),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_rdata    (i_mem_rdata),
    .i_mem_ready    (i_mem_ready)
`ifdef MEM_SEQ_STATS_EN
    ,
    .o_instr_count  (o_instr_count),
    .o_wait_cycles  (o_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: 64 words, slow_addr answers after slow_waits wait cycles.
  logic [31:0] ram [64];
  logic [31:0] slow_addr;
  int          slow_waits;
  int          wcnt = 0;
  int          waits_now;

  assign waits_now   = (o_mem_addr == slow_addr) ? slow_waits : 0;
  assign i_mem_ready = o_mem_req && (wcnt >= waits_now);
  assign i_mem_rdata = ram[o_mem_addr[5:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'(i) * 32'h01010101;
      ram[0]  <= 32'h00500093;
      ram[4]  <= 32'h00A00113;
      ram[16] <= 32'hDEADBEEF;
      ram[32] <= 32'h11223344;
    end else if (o_mem_req && i_mem_ready && o_mem_we) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_be[b]) ram[o_mem_addr[5:0]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
    if (o_mem_req && !i_mem_ready) wcnt <= wcnt + 1;
    else                           wcnt <= 0;
  end

  // Monitor: handshake log, commit log, request/write cycle counts, hold rule.
  typedef struct {
    int          cyc;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } hs_t;
  hs_t hs_q[$];
  int  cm_q[$];
  int  n_req_cyc = 0;
  int  n_we_cyc  = 0;
  int  n_hold_err = 0;

  always @(negedge clk) begin
    static logic        p_wait = 1'b0;
    static logic        p_we;
    static logic [3:0]  p_be;
    static logic [31:0] p_addr, p_wdata;
    if (p_wait && (o_mem_req !== 1'b1 || o_mem_we !== p_we || o_mem_be !== p_be ||
                   o_mem_addr !== p_addr || o_mem_wdata !== p_wdata) && !rst)
      n_hold_err <= n_hold_err + 1;
    p_wait  = (o_mem_req === 1'b1) && (i_mem_ready === 1'b0) && !rst;
    p_we    = o_mem_we;
    p_be    = o_mem_be;
    p_addr  = o_mem_addr;
    p_wdata = o_mem_wdata;
    if (o_mem_req === 1'b1) n_req_cyc <= n_req_cyc + 1;
    if (o_mem_req === 1'b1 && o_mem_we === 1'b1) n_we_cyc <= n_we_cyc + 1;
    if (o_mem_req === 1'b1 && i_mem_ready === 1'b1)
      hs_q.push_back('{cyc, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata});
    if (o_core_clk_en === 1'b1) cm_q.push_back(cyc);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int c0, hs_base, cm_base, req_base, we_base;

  function automatic int hs_n();
    return hs_q.size() - hs_base;
  endfunction

  function automatic int cm_n();
    return cm_q.size() - cm_base;
  endfunction

  function automatic hs_t hs_at(input int k);
    hs_t h = '{-1000, 1'bx, 4'hx, 32'hx, 32'hx};
    if (hs_base + k < hs_q.size()) h = hs_q[hs_base + k];
    return h;
  endfunction

  function automatic int cm_at(input int k);
    if (cm_base + k < cm_q.size()) return cm_q[cm_base + k] - c0;
    return -1000;
  endfunction

  task automatic mark();
    c0       = cyc;
    hs_base  = hs_q.size();
    cm_base  = cm_q.size();
    req_base = n_req_cyc;
    we_base  = n_we_cyc;
  endtask

  // Cycle c0 is the first cycle with rst low: state S_FETCH, no request yet.
  task automatic do_reset(input bit chk_zero);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    if (chk_zero) begin
      check("rst_req",    32'(o_mem_req),     0);
      check("rst_clk_en", 32'(o_core_clk_en), 0);
      check("rst_we",     32'(o_mem_we),      0);
      check("rst_be",     32'(o_mem_be),      0);
      check("rst_addr",   o_mem_addr,         0);
      check("rst_wdata",  o_mem_wdata,        0);
      check("rst_fdata",  o_fetch_data,       0);
      check("rst_rdata",  o_read_data,        0);
    end
    mark();
    rst = 1'b0;
  endtask

  task automatic run_to(input int k);
    while (cyc < c0 + k) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    i_fetch_addr = '0; i_read_req = 1'b0; i_read_addr = '0;
    i_write_enable = 1'b0; i_byte_enable = '0; i_write_addr = '0; i_write_data = '0;
    i_halt = 1'b0; slow_addr = '1; slow_waits = 0;

    // 1: plain ALU instruction, zero wait states
    do_reset(1'b1);
    run_to(3);
    check("t1_fetch_n",    32'(hs_n()), 1);
    check("t1_fetch_addr", hs_at(0).addr, 0);
    check("t1_fetch_cyc",  32'(hs_at(0).cyc - c0), 1);
    check("t1_commit_cyc", 32'(cm_at(0)), 3);
    check("t1_fetch_data", o_fetch_data, 32'h00500093);
    run_to(6);
    check("t1_period",     32'(cm_at(1) - cm_at(0)), 3);
    check("t1_fetch2_cyc", 32'(hs_at(1).cyc - c0), 4);

    // 2: load with two wait states
    i_read_req = 1'b1; i_read_addr = 32'h10; slow_addr = 32'h10; slow_waits = 2;
    do_reset(1'b0);
    run_to(4);
    check("t2_rdata_wait", o_read_data, 0);
    run_to(6);
    check("t2_commit_cyc", 32'(cm_at(0)), 6);
    check("t2_rd_addr",    hs_at(1).addr, 32'h10);
    check("t2_rd_we",      32'(hs_at(1).we), 0);
    check("t2_rd_cyc",     32'(hs_at(1).cyc - c0), 5);
    check("t2_rdata",      o_read_data, 32'hDEADBEEF);
`ifdef MEM_SEQ_STATS_EN
    check("t2_wait_cnt",   o_wait_cycles, 2);
`endif

    // 3: store byte
    i_read_req = 1'b0; i_write_enable = 1'b1; i_byte_enable = 4'b0001;
    i_write_addr = 32'h20; i_write_data = 32'h000000AB;
    do_reset(1'b0);
    run_to(4);
    check("t3_we_cycles",  32'(n_we_cyc - we_base), 1);
    check("t3_wr_be",      32'(hs_at(1).be), 32'h1);
    check("t3_wr_addr",    hs_at(1).addr, 32'h20);
    check("t3_wr_wdata",   hs_at(1).wdata, 32'hAB);
    check("t3_commit_cyc", 32'(cm_at(0)), 4);
    check("t3_ram_word",   ram[32], 32'h112233AB);

    // 4: load and store in one instruction
    i_read_req = 1'b1; i_read_addr = 32'h10; slow_waits = 1;
    i_write_enable = 1'b1; i_byte_enable = 4'b1111;
    i_write_addr = 32'h21; i_write_data = 32'hCAFEF00D;
    do_reset(1'b0);
    run_to(5);
    check("t4_gap_req",    32'(o_mem_req), 0);
    run_to(7);
    check("t4_rd_cyc",     32'(hs_at(1).cyc - c0), 4);
    check("t4_rd_we",      32'(hs_at(1).we), 0);
    check("t4_wr_cyc",     32'(hs_at(2).cyc - c0), 6);
    check("t4_wr_we",      32'(hs_at(2).we), 1);
    check("t4_commit_n",   32'(cm_n()), 1);
    check("t4_commit_cyc", 32'(cm_at(0)), 7);
    check("t4_rdata",      o_read_data, 32'hDEADBEEF);
    check("t4_ram_word",   ram[33], 32'hCAFEF00D);

    // 5: halt at commit
    i_read_req = 1'b0; i_write_enable = 1'b0; i_halt = 1'b1;
    do_reset(1'b0);
    run_to(23);
    check("t5_commit_n",   32'(cm_n()), 1);
    check("t5_req_cycles", 32'(n_req_cyc - req_base), 1);
    check("t5_req_now",    32'(o_mem_req), 0);
`ifdef MEM_SEQ_STATS_EN
    check("t5_instr_cnt",  o_instr_count, 1);
`endif

    // 6: reset during a stalled load
    i_halt = 1'b0; i_fetch_addr = 32'h4; i_read_req = 1'b1;
    i_read_addr = 32'h10; slow_waits = 100;
    do_reset(1'b0);
    run_to(5);
    check("t6_stalled",    32'(o_mem_req), 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t6_req_drop",   32'(o_mem_req), 0);
    check("t6_clk_en",     32'(o_core_clk_en), 0);
    check("t6_commit_n",   32'(cm_n()), 0);
    check("t6_fdata_clr",  o_fetch_data, 0);
`ifdef MEM_SEQ_STATS_EN
    check("t6_instr_cnt",  o_instr_count, 0);
    check("t6_wait_cnt",   o_wait_cycles, 0);
`endif
    i_read_req = 1'b0; i_fetch_addr = 32'h5;
    mark();
    rst = 1'b0;
    run_to(3);
    check("t6_refetch_n",    32'(hs_n()), 1);
    check("t6_refetch_addr", hs_at(0).addr, 32'h5);
    check("t6_refetch_cyc",  32'(hs_at(0).cyc - c0), 1);
    check("t6_commit_cyc",   32'(cm_at(0)), 3);
    check("t6_fetch_data",   o_fetch_data, 32'h05050505);

    check("hold_stable", 32'(n_hold_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
